sha256_block_loader: RTL and testbench



---
 rtl/sha256_pkg.sv | 38 +++
 rtl/sha256_block_loader.sv | 181 ++++++++++++++++++
 tb/tb_sha256_block_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: constants and types shared by the SHA-256 front end and core.
//   BLOCK_BITS / LEN_BITS / PAD_BYTE / LEN_OFFSET : padding geometry
//   loader_state_t                                : block loader FSM states
//   SHA256_K / SHA256_H0                          : round constants, initial hash
package sha256_pkg;

  localparam int          BLOCK_BITS = 512;
  localparam int          LEN_BITS   = 64;
  localparam logic [7:0]  PAD_BYTE   = 8'h80;
  localparam int          LEN_OFFSET = 56;

  typedef enum logic [1:0] {FILL, EMIT, TAIL} loader_state_t;

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_block_loader.sv
// sha256_block_loader: byte-stream to padded 512-bit block front end.
//   clk, reset                          : clock, async active-high reset
//   in_valid/in_ready/in_data/in_last/in_nbytes : message beats, IN_BYTES wide,
//                                         first byte in the MSBs
//   blk_valid/blk_ready/blk_data        : 512-bit blocks, byte 0 at [511:504]
//   blk_first/blk_last                  : block position within its message
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 1,
  parameter int CNT_W    = 61,
  localparam int NB_W    = $clog2(IN_BYTES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic                   in_last,
  input  logic [NB_W-1:0]        in_nbytes,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [BLOCK_BITS-1:0]  blk_data,
  output logic                   blk_first,
  output logic                   blk_last
);

  typedef logic [0:63][7:0] blk_buf_t;  // index 0 lands in the MSBs

  loader_state_t     state_q, state_d;
  blk_buf_t          buf_q, buf_d;
  logic [5:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_pend_q, first_pend_d;
  logic              pend_len_q, pend_len_d;
  logic              need80_q, need80_d;
  logic              last_q, last_d;

  logic [6:0]        p_fill;   // write pointer after the current beat, 0..71
  logic [CNT_W-1:0]  cnt_new;
  logic              beat;

  assign p_fill  = 7'(ptr_q) + 7'(in_nbytes);
  assign cnt_new = cnt_q + CNT_W'(in_nbytes);
  assign beat    = in_valid && in_ready;

  // Bit length {count, 3'b000}, zero-extended or truncated to 64 bits.
  function automatic logic [LEN_BITS-1:0] len_of(input logic [CNT_W-1:0] c);
    logic [CNT_W+66:0] w;
    w = {64'b0, c, 3'b000};
    return w[LEN_BITS-1:0];
  endfunction

  function automatic blk_buf_t put_len(input blk_buf_t b, input logic [LEN_BITS-1:0] len);
    for (int i = 0; i < 8; i++) b[6'(LEN_OFFSET + i)] = len[63-8*i -: 8];
    return b;
  endfunction

  // Byte-lane write of one beat starting at ptr; lanes beyond nb untouched.
  function automatic blk_buf_t put_lanes(input blk_buf_t b, input logic [5:0] ptr,
                                         input logic [8*IN_BYTES-1:0] data,
                                         input logic [NB_W-1:0] nb);
    logic [6:0] idx;
    for (int k = 0; k < IN_BYTES; k++) begin
      idx = 7'(ptr) + 7'(k);
      if (k < int'(nb) && !idx[6]) b[idx[5:0]] = data[8*(IN_BYTES-k)-1 -: 8];
    end
    return b;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (beat && (in_last || p_fill >= 7'd64)) state_d = EMIT;
      EMIT:    if (blk_ready) state_d = pend_len_q ? TAIL : FILL;
      TAIL:    state_d = EMIT;
      default: state_d = FILL;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == FILL) && !reset;
    blk_valid = (state_q == EMIT);
    blk_first = blk_valid && first_pend_q;
    blk_last  = blk_valid && last_q;
    blk_data  = buf_q;
  end

  // Datapath
  always_comb begin
    buf_d        = buf_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    pend_len_d   = pend_len_q;
    need80_d     = need80_q;
    last_d       = last_q;
    unique case (state_q)
      FILL: if (beat) begin
        buf_d = put_lanes(buf_q, ptr_q, in_data, in_nbytes);
        cnt_d = cnt_new;
        if (!in_last) begin
          ptr_d  = p_fill[5:0];        // wraps to 0 on a full block
          last_d = 1'b0;
        end else begin
          ptr_d = '0;
          if (p_fill <= 7'd55) begin
            // buffer is already zero past p, only marker and length remain
            buf_d[p_fill[5:0]] = PAD_BYTE;
            buf_d              = put_len(buf_d, len_of(cnt_new));
            last_d             = 1'b1;
          end else if (p_fill <= 7'd63) begin
            buf_d[p_fill[5:0]] = PAD_BYTE;
            last_d             = 1'b0;
            pend_len_d         = 1'b1;
            need80_d           = 1'b0;
          end else begin
            last_d     = 1'b0;
            pend_len_d = 1'b1;
            need80_d   = 1'b1;
          end
        end
      end
      EMIT: if (blk_ready) begin
        first_pend_d = 1'b0;
        if (!pend_len_q) begin
          buf_d = '0;
          if (last_q) begin
            cnt_d        = '0;
            first_pend_d = 1'b1;
          end
        end
      end
      TAIL: begin
        buf_d = '0;
        if (need80_q) buf_d[0] = PAD_BYTE;
        buf_d      = put_len(buf_d, len_of(cnt_q));
        pend_len_d = 1'b0;
        last_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      first_pend_q <= 1'b1;
      pend_len_q   <= 1'b0;
      need80_q     <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      pend_len_q   <= pend_len_d;
      need80_q     <= need80_d;
      last_q       <= last_d;
    end
  end

  // Illegal beat sizes have no recovery path; flag them in simulation.
  always @(posedge clk) begin
    if (!reset && beat) begin
      assert (int'(in_nbytes) <= IN_BYTES);
      assert (in_last || int'(in_nbytes) == IN_BYTES);
    end
  end

endmodule

// File: tb/tb_sha256_block_loader.sv
module tb_sha256_block_loader;

  localparam int IN_BYTES = 4;
  localparam int CNT_W    = 9;   // small counter so the wrap is reachable
  localparam int NB_W     = $clog2(IN_BYTES) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [8*IN_BYTES-1:0] in_data = '0;
  logic                  in_last = 1'b0;
  logic [NB_W-1:0]       in_nbytes = '0;
  logic                  blk_valid;
  logic                  blk_ready = 1'b0;
  logic [511:0]          blk_data;
  logic                  blk_first;
  logic                  blk_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_q[$];

  sha256_block_loader #(.IN_BYTES(IN_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_exp();
    logic [7:0]   pad[$];
    logic [63:0]  lenbits;
    logic [511:0] blk;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    lenbits = 64'(msg_q.size() % (1 << CNT_W)) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(lenbits[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < pad.size() / 64; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pad[64*b + i];
      exp_q.push_back(blk);
    end
  endtask

  // Streams msg_q and checks every cycle a block is presented.
  task automatic run_msg(input int stall_first, input bit rand_bp);
    int idx = 0, got = 0, cyc = 0, stall = stall_first, rem, nb;
    bit sent = 0, lat_chk = 0;
    build_exp();
    while (got < exp_q.size() && cyc < 5000) begin
      @(negedge clk); cyc++;
      in_valid = 0; in_last = 0; in_nbytes = '0; in_data = '0; blk_ready = 0;
      if (lat_chk) begin chk("latency_valid", 512'(blk_valid), 512'(1)); lat_chk = 0; end
      if (blk_valid) begin
        chk("ready_in_emit", 512'(in_ready), 512'(0));
        chk("blk_data", blk_data, exp_q[got]);
        chk("blk_first", 512'(blk_first), 512'(got == 0));
        chk("blk_last", 512'(blk_last), 512'(got == exp_q.size() - 1));
        if (stall > 0) stall--;
        else if (!(rand_bp && $urandom_range(0, 3) == 0)) begin blk_ready = 1; got++; end
      end
      if (!sent && in_ready && !(rand_bp && $urandom_range(0, 4) == 0)) begin
        rem = msg_q.size() - idx;
        nb  = (rem > IN_BYTES) ? IN_BYTES : rem;
        for (int k = 0; k < nb; k++) in_data[8*(IN_BYTES-k)-1 -: 8] = msg_q[idx + k];
        in_valid = 1; in_last = (rem <= IN_BYTES); in_nbytes = NB_W'(nb);
        idx += nb;
        if (rem <= IN_BYTES) begin sent = 1; lat_chk = 1; end
      end
    end
    chk("blocks_received", 512'(got), 512'(exp_q.size()));
  endtask

  task automatic send_full_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1; in_last = 0; in_nbytes = NB_W'(IN_BYTES); in_data = $urandom;
    end
    @(negedge clk);
    in_valid = 0; in_data = '0; in_nbytes = '0;
  endtask

  task automatic reset_and_check(input string tag);
    #2 reset = 1;
    #1;
    chk({tag, "_rst_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_rst_data"}, blk_data, 512'(0));
    chk({tag, "_rst_first"}, 512'(blk_first), 512'(0));
    chk({tag, "_rst_last"}, 512'(blk_last), 512'(0));
    chk({tag, "_rst_ready"}, 512'(in_ready), 512'(0));
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 512'(in_ready), 512'(1));
  endtask

  task automatic set_abc();
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
  endtask

  task automatic set_msg(input int len, input bit zeros);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(zeros ? 8'h00 : 8'($urandom));
  endtask

  initial begin
    // power-on reset
    #1 reset = 1;
    @(negedge clk);
    chk("por_valid", 512'(blk_valid), 512'(0));
    chk("por_data", blk_data, 512'(0));
    chk("por_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("por_ready_after", 512'(in_ready), 512'(1));

    set_abc();          run_msg(0, 0);   // single block, first=last
    set_msg(0, 0);      run_msg(0, 0);   // empty message
    set_msg(55, 0);     run_msg(0, 0);   // marker at 55, length fits
    set_msg(56, 1);     run_msg(0, 0);   // marker at 56, length spills
    set_msg(63, 0);     run_msg(0, 0);   // marker at 63
    set_msg(64, 0);     run_msg(0, 0);   // full block, marker in tail block
    set_abc();          run_msg(5, 0);   // held output under backpressure
    set_msg(130, 0);    run_msg(2, 0);   // multi-block message

    // reset mid-message discards the partial bytes
    send_full_beats(8);
    reset_and_check("mid_msg");
    set_abc();          run_msg(0, 0);

    // reset while a block is being offered
    send_full_beats(16);
    chk("emit_before_reset", 512'(blk_valid), 512'(1));
    reset_and_check("mid_emit");
    set_abc();          run_msg(0, 0);

    // random lengths with random stalls on both sides
    for (int t = 0; t < 20; t++) begin
      set_msg($urandom_range(0, 200), 0);
      run_msg(0, 1);
    end

    // byte count wraps modulo 2^CNT_W
    set_msg(530, 0);    run_msg(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
